// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: ALUop encodings from the controller,
// ALU operation codes and the EX/MEM pipeline register payload.
package execute_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned FUNCT_W  = 4;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluCtrlT;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluOpT;

  typedef struct packed {
    logic [XLEN_DEF-1:0] aluResult;
    logic [XLEN_DEF-1:0] writeData;
    logic [XLEN_DEF-1:0] branchTarget;
    logic [REG_AW-1:0]   writeReg;
    logic                memToReg;
    logic                regWrite;
    logic                memRead;
    logic                memWrite;
    logic                branchTaken;
    logic                zero;
  } exMemT;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, WB forwarding source, pipeline control and EX/MEM outputs
// of the execute stage bundled as one bus.
interface execute_stage_if import execute_stage_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic              stall;
  logic              flush;
  logic              ALUscrE;
  logic              memToRegE;
  logic              regWriteE;
  logic              memReadE;
  logic              memWriteE;
  logic              branchE;
  logic [1:0]        ALUopE;
  logic [FUNCT_W-1:0] funct_E;
  logic [REG_AW-1:0] write_regE;
  logic [REG_AW-1:0] read_regE1;
  logic [REG_AW-1:0] read_regE2;
  logic [XLEN-1:0]   read_dataE1;
  logic [XLEN-1:0]   read_dataE2;
  logic [XLEN-1:0]   PC_E;
  logic [XLEN-1:0]   GenOutE;
  logic              regWriteW;
  logic [REG_AW-1:0] write_regW;
  logic [XLEN-1:0]   write_dataW;

  logic [XLEN-1:0]   ALUresultM;
  logic [XLEN-1:0]   write_dataM;
  logic [XLEN-1:0]   branch_targetM;
  logic [REG_AW-1:0] write_regM;
  logic              memToRegM;
  logic              regWriteM;
  logic              memReadM;
  logic              memWriteM;
  logic              branch_takenM;
  logic              zeroM;

  modport master (
    output stall, flush, ALUscrE, memToRegE, regWriteE, memReadE, memWriteE,
           branchE, ALUopE, funct_E, write_regE, read_regE1, read_regE2,
           read_dataE1, read_dataE2, PC_E, GenOutE,
           regWriteW, write_regW, write_dataW,
    input  ALUresultM, write_dataM, branch_targetM, write_regM,
           memToRegM, regWriteM, memReadM, memWriteM, branch_takenM, zeroM
  );

  modport slave (
    input  stall, flush, ALUscrE, memToRegE, regWriteE, memReadE, memWriteE,
           branchE, ALUopE, funct_E, write_regE, read_regE1, read_regE2,
           read_dataE1, read_dataE2, PC_E, GenOutE,
           regWriteW, write_regW, write_dataW,
    output ALUresultM, write_dataM, branch_targetM, write_regM,
           memToRegM, regWriteM, memReadM, memWriteM, branch_takenM, zeroM
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational integer ALU: modulo-2^XLEN arithmetic, shifts by b[log2(XLEN)-1:0].
module alu import execute_stage_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  aluOpT           op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           ltSigned;
  logic           ltUnsigned;

  assign shamt      = b[SHW-1:0];
  assign ltSigned   = $signed(a) < $signed(b);
  assign ltUnsigned = a < b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ltSigned};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltUnsigned};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand forwarding from MEM/WB, ALU control decode,
// branch resolution and the EX/MEM register with stall/flush/reset.
module execute_stage import execute_stage_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input logic             clock,
  input logic             reset,
  execute_stage_if.slave  bus
);

  logic [XLEN-1:0] fwdA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;
  logic            aluZero;
  aluOpT           aluOp;
  logic            takenRaw;
  logic [2:0]      funct3;
  logic            functAlt;
  exMemT           exMemD;
  exMemT           exMemQ;

  assign funct3   = bus.funct_E[2:0];
  assign functAlt = bus.funct_E[3];

  // A producer forwards only if it writes a non-x0 register matching the source.
  function automatic logic fwdHit(input logic regWrite, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs);
    return regWrite && (rd != '0) && (rd == rs);
  endfunction

  // MEM result wins over WB when both target the same register.
  always_comb begin
    fwdA = bus.read_dataE1;
    if (fwdHit(exMemQ.regWrite, exMemQ.writeReg, bus.read_regE1))
      fwdA = exMemQ.aluResult;
    else if (fwdHit(bus.regWriteW, bus.write_regW, bus.read_regE1))
      fwdA = bus.write_dataW;

    fwdB = bus.read_dataE2;
    if (fwdHit(exMemQ.regWrite, exMemQ.writeReg, bus.read_regE2))
      fwdB = exMemQ.aluResult;
    else if (fwdHit(bus.regWriteW, bus.write_regW, bus.read_regE2))
      fwdB = bus.write_dataW;
  end

  assign srcB = bus.ALUscrE ? bus.GenOutE : fwdB;

  // ALU control: I-type funct3=000 is always add since instr[30] is immediate bits.
  always_comb begin
    aluOp = ALU_ADD;
    case (aluCtrlT'(bus.ALUopE))
      ALUOP_ADD:    aluOp = ALU_ADD;
      ALUOP_BRANCH: aluOp = ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          3'b000: aluOp = (functAlt && (aluCtrlT'(bus.ALUopE) == ALUOP_RTYPE)) ? ALU_SUB : ALU_ADD;
          3'b001: aluOp = ALU_SLL;
          3'b010: aluOp = ALU_SLT;
          3'b011: aluOp = ALU_SLTU;
          3'b100: aluOp = ALU_XOR;
          3'b101: aluOp = functAlt ? ALU_SRA : ALU_SRL;
          3'b110: aluOp = ALU_OR;
          3'b111: aluOp = ALU_AND;
          default: aluOp = ALU_ADD;
        endcase
      end
    endcase
  end

  alu #(.XLEN(XLEN)) uAlu (
    .a      (fwdA),
    .b      (srcB),
    .op     (aluOp),
    .result (aluResult),
    .zero   (aluZero)
  );

  always_comb begin
    case (funct3)
      3'b000:  takenRaw = aluZero;
      3'b001:  takenRaw = !aluZero;
      default: takenRaw = 1'b0;
    endcase
  end

  // Next EX/MEM contents; flush turns the instruction into a bubble.
  always_comb begin
    exMemD              = '0;
    exMemD.aluResult    = aluResult;
    exMemD.writeData    = fwdB;
    exMemD.branchTarget = bus.PC_E + bus.GenOutE;
    exMemD.writeReg     = bus.write_regE;
    exMemD.memToReg     = bus.memToRegE;
    exMemD.regWrite     = bus.regWriteE;
    exMemD.memRead      = bus.memReadE;
    exMemD.memWrite     = bus.memWriteE;
    exMemD.branchTaken  = bus.branchE & takenRaw;
    exMemD.zero         = aluZero;
    if (bus.flush) begin
      exMemD.memToReg    = 1'b0;
      exMemD.regWrite    = 1'b0;
      exMemD.memRead     = 1'b0;
      exMemD.memWrite    = 1'b0;
      exMemD.branchTaken = 1'b0;
    end
  end

  // Reset beats flush, flush beats stall.
  always_ff @(posedge clock) begin
    if (reset)
      exMemQ <= '0;
    else if (bus.flush || !bus.stall)
      exMemQ <= exMemD;
  end

  assign bus.ALUresultM     = exMemQ.aluResult;
  assign bus.write_dataM    = exMemQ.writeData;
  assign bus.branch_targetM = exMemQ.branchTarget;
  assign bus.write_regM     = exMemQ.writeReg;
  assign bus.memToRegM      = exMemQ.memToReg;
  assign bus.regWriteM      = exMemQ.regWrite;
  assign bus.memReadM       = exMemQ.memRead;
  assign bus.memWriteM      = exMemQ.memWrite;
  assign bus.branch_takenM  = exMemQ.branchTaken;
  assign bus.zeroM          = exMemQ.zero;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed instructions push hand-computed
// EX/MEM expectations, a monitor pops one per clock and compares.
module tb_execute_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  execute_stage_if #(.XLEN(32)) bus ();

  execute_stage #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, stall, flush, aluSrc, memToReg, regWrite, memRead, memWrite, branch;
    logic [1:0]  aluOp;
    logic [3:0]  funct;
    logic [4:0]  wr, rs1, rs2;
    logic [31:0] rd1, rd2, pc, imm;
    logic        regWriteW;
    logic [4:0]  wrW;
    logic [31:0] wdW;
  } stimT;

  typedef struct {
    logic [31:0] alu, wd, bt;
    logic [4:0]  wr;
    logic [4:0]  ctrl;  // {memToReg, regWrite, memRead, memWrite, branchTaken}
    logic        zero;
    bit          chkData, chkZero;
  } expT;

  expT sb[$];
  expT cur;
  int  nCompared = 0;
  int  nMiss     = 0;

  function automatic stimT nop();
    stimT s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stimT rop(input logic [3:0] funct, input logic [4:0] wr, rs1, rs2,
                               input logic [31:0] rd1, rd2);
    stimT s;
    s = nop();
    s.aluOp = 2'b10; s.regWrite = 1'b1; s.funct = funct;
    s.wr = wr; s.rs1 = rs1; s.rs2 = rs2; s.rd1 = rd1; s.rd2 = rd2;
    return s;
  endfunction

  function automatic stimT iop(input logic [3:0] funct, input logic [4:0] wr, rs1,
                               input logic [31:0] rd1, imm);
    stimT s;
    s = nop();
    s.aluOp = 2'b11; s.aluSrc = 1'b1; s.regWrite = 1'b1; s.funct = funct;
    s.wr = wr; s.rs1 = rs1; s.rd1 = rd1; s.imm = imm;
    return s;
  endfunction

  function automatic expT ex(input logic [31:0] alu, wd, bt, input logic [4:0] wr,
                             input logic [4:0] ctrl, input logic zero);
    expT e;
    e.alu = alu; e.wd = wd; e.bt = bt; e.wr = wr; e.ctrl = ctrl; e.zero = zero;
    e.chkData = 1'b1; e.chkZero = 1'b1;
    return e;
  endfunction

  task automatic run(input stimT s, input expT e);
    @(negedge clock);
    reset           = s.rst;
    bus.stall       = s.stall;
    bus.flush       = s.flush;
    bus.ALUscrE     = s.aluSrc;
    bus.memToRegE   = s.memToReg;
    bus.regWriteE   = s.regWrite;
    bus.memReadE    = s.memRead;
    bus.memWriteE   = s.memWrite;
    bus.branchE     = s.branch;
    bus.ALUopE      = s.aluOp;
    bus.funct_E     = s.funct;
    bus.write_regE  = s.wr;
    bus.read_regE1  = s.rs1;
    bus.read_regE2  = s.rs2;
    bus.read_dataE1 = s.rd1;
    bus.read_dataE2 = s.rd2;
    bus.PC_E        = s.pc;
    bus.GenOutE     = s.imm;
    bus.regWriteW   = s.regWriteW;
    bus.write_regW  = s.wrW;
    bus.write_dataW = s.wdW;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s (vector %0d): got %h expected %h", name, nCompared, act, exp);
    end
  endtask

  // Monitor: each clock presents the result of the instruction issued before it.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if (cur.chkData) begin
        check("ALUresultM", bus.ALUresultM, cur.alu);
        check("write_dataM", bus.write_dataM, cur.wd);
        check("branch_targetM", bus.branch_targetM, cur.bt);
        check("write_regM", 32'(bus.write_regM), 32'(cur.wr));
      end
      check("ctrl", 32'({bus.memToRegM, bus.regWriteM, bus.memReadM, bus.memWriteM,
                         bus.branch_takenM}), 32'(cur.ctrl));
      if (cur.chkZero)
        check("zeroM", 32'(bus.zeroM), 32'(cur.zero));
    end
  end

  initial begin
    stimT s;
    expT  e;

    // reset with a live instruction on the inputs
    s = rop(4'b0000, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7); s.rst = 1'b1;
    run(s, ex(32'd0, 32'd0, 32'd0, 5'd0, 5'b00000, 1'b0));
    // add x3,x1,x2
    run(rop(4'b0000, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7),
        ex(32'd12, 32'd7, 32'd0, 5'd3, 5'b01000, 1'b0));
    // sub x4,x3,x1 with stale x3: MEM forward
    run(rop(4'b1000, 5'd4, 5'd3, 5'd1, 32'd0, 32'd5),
        ex(32'd7, 32'd5, 32'd0, 5'd4, 5'b01000, 1'b0));
    // addi x6,x0,9
    run(iop(4'b0000, 5'd6, 5'd0, 32'd0, 32'd9),
        ex(32'd9, 32'd0, 32'd9, 5'd6, 5'b01000, 1'b0));
    // add x7,x6,x6: MEM (9) beats WB (4)
    s = rop(4'b0000, 5'd7, 5'd6, 5'd6, 32'd100, 32'd100);
    s.regWriteW = 1'b1; s.wrW = 5'd6; s.wdW = 32'd4;
    run(s, ex(32'd18, 32'd9, 32'd0, 5'd7, 5'b01000, 1'b0));
    // add x0,x1,x2: regWriteM=1 with write_regM=0
    run(rop(4'b0000, 5'd0, 5'd1, 5'd2, 32'd1, 32'd2),
        ex(32'd3, 32'd2, 32'd0, 5'd0, 5'b01000, 1'b0));
    // add x8,x0,x0: neither MEM nor WB may forward into x0
    s = rop(4'b0000, 5'd8, 5'd0, 5'd0, 32'd10, 32'd20);
    s.regWriteW = 1'b1; s.wrW = 5'd0; s.wdW = 32'd99;
    run(s, ex(32'd30, 32'd20, 32'd0, 5'd8, 5'b01000, 1'b0));
    // add x9,x11,x8: A from WB, B from MEM
    s = rop(4'b0000, 5'd9, 5'd11, 5'd8, 32'd0, 32'd0);
    s.regWriteW = 1'b1; s.wrW = 5'd11; s.wdW = 32'd40;
    run(s, ex(32'd70, 32'd30, 32'd0, 5'd9, 5'b01000, 1'b0));
    // sra, slt, sltu
    run(rop(4'b1101, 5'd10, 5'd12, 5'd13, 32'h8000_0000, 32'h21),
        ex(32'hC000_0000, 32'h21, 32'd0, 5'd10, 5'b01000, 1'b0));
    run(rop(4'b0010, 5'd26, 5'd14, 5'd15, 32'hFFFF_FFFF, 32'd1),
        ex(32'd1, 32'd1, 32'd0, 5'd26, 5'b01000, 1'b0));
    run(rop(4'b0011, 5'd27, 5'd14, 5'd15, 32'hFFFF_FFFF, 32'd1),
        ex(32'd0, 32'd1, 32'd0, 5'd27, 5'b01000, 1'b1));
    // beq taken, backward target
    s = nop(); s.branch = 1'b1; s.aluOp = 2'b01; s.funct = 4'b0000;
    s.rs1 = 5'd16; s.rs2 = 5'd17; s.rd1 = 32'h10; s.rd2 = 32'h10;
    s.pc = 32'h40; s.imm = 32'hFFFF_FFF8;
    run(s, ex(32'd0, 32'h10, 32'h38, 5'd0, 5'b00001, 1'b1));
    // bne taken
    s = nop(); s.branch = 1'b1; s.aluOp = 2'b01; s.funct = 4'b0001;
    s.rs1 = 5'd16; s.rs2 = 5'd17; s.rd1 = 32'd5; s.rd2 = 32'd3;
    s.pc = 32'h100; s.imm = 32'd8;
    run(s, ex(32'd2, 32'd3, 32'h108, 5'd0, 5'b00001, 1'b0));
    // srai by 4, then addi with instr[30]-like bit set stays add
    run(iop(4'b1101, 5'd29, 5'd28, 32'hF000_0000, 32'h404),
        ex(32'hFF00_0000, 32'd0, 32'h404, 5'd29, 5'b01000, 1'b0));
    run(iop(4'b1000, 5'd20, 5'd30, 32'd10, 32'd3),
        ex(32'd13, 32'd0, 32'd3, 5'd20, 5'b01000, 1'b0));
    // sw: store data forwarded from MEM x20, address uses immediate
    s = nop(); s.aluSrc = 1'b1; s.memWrite = 1'b1; s.rs1 = 5'd18; s.rs2 = 5'd20;
    s.rd1 = 32'h100; s.rd2 = 32'hDEAD; s.imm = 32'd4;
    run(s, ex(32'h104, 32'd13, 32'd4, 5'd0, 5'b00010, 1'b0));
    // lw x21
    s = nop(); s.aluSrc = 1'b1; s.memToReg = 1'b1; s.regWrite = 1'b1; s.memRead = 1'b1;
    s.wr = 5'd21; s.rd1 = 32'h200; s.imm = 32'h10;
    e = ex(32'h210, 32'd0, 32'h10, 5'd21, 5'b11100, 1'b0);
    run(s, e);
    // two stall cycles hold the lw, then flush during stall
    s = rop(4'b0000, 5'd22, 5'd1, 5'd1, 32'd1, 32'd1); s.stall = 1'b1; s.memWrite = 1'b1;
    run(s, e);
    run(s, e);
    s.flush = 1'b1;
    e = ex(32'd0, 32'd0, 32'd0, 5'd0, 5'b00000, 1'b0); e.chkData = 1'b0; e.chkZero = 1'b0;
    run(s, e);
    // flushed x22 must not forward
    run(rop(4'b0000, 5'd23, 5'd22, 5'd25, 32'd2, 32'd3),
        ex(32'd5, 32'd3, 32'd0, 5'd23, 5'b01000, 1'b0));
    // reset mid-run, then resume
    s = rop(4'b0000, 5'd24, 5'd1, 5'd2, 32'd8, 32'd9); s.rst = 1'b1;
    run(s, ex(32'd0, 32'd0, 32'd0, 5'd0, 5'b00000, 1'b0));
    run(rop(4'b0000, 5'd5, 5'd23, 5'd2, 32'd6, 32'd7),
        ex(32'd13, 32'd7, 32'd0, 5'd5, 5'b01000, 1'b0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      nCompared++;
      nMiss++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nCompared, nMiss);
    $finish;
  end

endmodule
